otn_rx_deser_ack: RTL
=====================

// Module: otn_rx_deser_ack
// PURPOSE
//  Receive-side partner of the sender transmit/retransmit stage. Oversamples the serial OTN line,
//  finds frame alignment on the FAS, deserializes bytes (LSB first) and passes them to the demapper.
//  When the demapper returns a frame verdict, this block serializes the 3-bit ACK back to the
//  sender: line idles high, then start bit 0, then the ACK bit (1 = good, 0 = bad), then stop bit 0.
// PARAMETERS
//  FRAME_BYTES  4164             total bytes per frame, FAS included
//  BAUD_DIV     20               i_sclk_en_16_x_baud ticks per bit
//  SAMPLE_PT    10               tick index (0..BAUD_DIV-1) at which a data bit is sampled
//  FAS          48'h282828F6F6F6 FAS pattern as held in the 48-bit shift register (first byte in [7:0])
//  CHK_TIMEOUT  65535            clocks to wait in CHK_WAIT for a verdict before sending a bad ACK
// PORTS
//  i_clk                 in   1  system clock
//  i_rst                 in   1  synchronous, active-high reset
//  i_sclk_en_16_x_baud   in   1  oversample enable, one i_clk wide
//  i_otn_rx_data         in   1  serial line from the sender; unregistered, async to bit phase
//  o_frame_data          out  8  deserialized byte
//  o_frame_data_valid    out  1  one-clock strobe per byte; no backpressure
//  o_frame_data_fas      out  1  one-clock strobe on FAS match, coincident with no data byte
//  o_frame_done          out  1  one-clock strobe after the last byte of a frame
//  i_chk_valid           in   1  demapper verdict strobe
//  i_chk_good            in   1  verdict: 1 = frame good; qualified by i_chk_valid
//  o_otn_tx_ack          out  1  serial ACK line back to the sender; idles at 1
//  o_rx_state            out  3  current FSM state, for debug LEDs
// BEHAVIOUR
//  Reset: state HUNT; o_otn_tx_ack=1; all strobes 0; o_frame_data=0; all counters 0.
//  Input sync: i_otn_rx_data passes through a 2-flop synchronizer on i_clk before any use.
//  Bit timing: a 5-bit tick counter advances on each i_sclk_en_16_x_baud and wraps BAUD_DIV-1 -> 0.
//   - In HUNT and RECV, a change in the synced input clears the tick counter to 0 (edge realign).
//   - A bit is sampled when an enable arrives with tick==SAMPLE_PT.
//   - During long runs without edges the counter free-runs, giving one sample per BAUD_DIV ticks.
//  FSM (3 bits):
//   HUNT=0: each sample shifts into the 48-bit register at bit 47 (shift right).
//           On a match with FAS, pulse o_frame_data_fas, clear the byte count, go to RECV.
//   RECV=1: each sample shifts into the 8-bit register (shift right). After 8 bits:
//           o_frame_data <= byte, o_frame_data_valid=1 for 1 clk, byte count +1 (13-bit).
//           When the count reaches FRAME_BYTES-6: pulse o_frame_done, go to CHK_WAIT.
//   CHK_WAIT=2: the line is ignored. On i_chk_valid, latch i_chk_good and go to ACK_START.
//           If the timeout counter reaches CHK_TIMEOUT, latch good=0 and go to ACK_START.
//   ACK_START=3 / ACK_BIT=4 / ACK_STOP=5: drive 0 / latched verdict / 0 respectively.
//           Each state lasts exactly one baud, i.e. BAUD_DIV enables, counted from tick 0 on entry.
//           ACK_STOP then returns to HUNT and o_otn_tx_ack returns to 1.
//   Codes 6 and 7: illegal; go to HUNT.
//  Edge cases:
//   - i_chk_valid outside CHK_WAIT is ignored.
//   - i_chk_valid coincident with the timeout: the verdict wins.
//   - The shift register is cleared on entry to HUNT, so a retransmitted frame re-aligns afresh.
//   - FAS-like data inside RECV is not re-matched.
//   - i_rst mid-frame or mid-ACK: the next clock is in HUNT with o_otn_tx_ack=1.
//     A partially sent ACK is abandoned; the sender treats the missing stop bit as line noise.
//   - Latency: o_frame_data_valid rises 1 clk after the sampling enable of bit 7.
//     FAS match to o_frame_data_fas is also 1 clk.
// STRUCTURE
//  Shared package otn_rx_pkg: the FAS constant; state localparams; BAUD_DIV and SAMPLE_PT defaults.
//  One sub-module, ack_ser. It takes the verdict bit and a start strobe, generates the
//  start/ack/stop sequence with its own baud counter, and reports busy.
//  Everything else stays flat: synchronizer, tick counter, hunt/recv shifters, FSM.
// TESTING
//  1. Send FAS plus 4158 bytes of incrementing data. Expect 1 fas strobe and 4158 valid strobes
//     with bytes 0x00..0xFF wrapping, then o_frame_done. Then drive i_chk_valid with i_chk_good=1:
//     o_otn_tx_ack reads 1,0,1,0,1, each of the middle three bits 20 enables long.
//  2. Same frame, but i_chk_good=0 -> ACK bit is 0, so the line holds 0 for 60 enables,
//     then returns to 1.
//  3. No verdict after o_frame_done -> after CHK_TIMEOUT clocks a bad ACK (0,0,0) is sent.
//  4. Send 0xF6F6F628 2828 preceded by 37 bits of random prefix and a 3-tick bit-phase offset.
//     Expect alignment on the true FAS, and the first data byte 0xA5 received correctly.
//  5. Assert i_rst at byte 2000 and again during ACK_BIT. Expect HUNT, o_otn_tx_ack=1, no strobes,
//     and a clean re-lock on the next frame.
//  6. Place the FAS bytes inside the payload of a locked frame. Expect no extra fas strobe and a
//     byte count unaffected.

Source files
------------

// File: rtl/otn_rx_deser_ack_pkg.sv
// Shared constants and state encodings for the OTN receive deserializer and its ACK return path.
package otn_rx_pkg;

    // FAS as it sits in the 48-bit hunt register: first byte on the line lands in [7:0]
    localparam logic [47:0] FAS = 48'h282828F6F6F6;

    localparam int FRAME_BYTES_DEF = 4164;
    localparam int BAUD_DIV_DEF    = 20;
    localparam int SAMPLE_PT_DEF   = 10;
    localparam int CHK_TIMEOUT_DEF = 65535;

    typedef enum logic [2:0] {
        ST_HUNT      = 3'd0,
        ST_RECV      = 3'd1,
        ST_CHK_WAIT  = 3'd2,
        ST_ACK_START = 3'd3,
        ST_ACK_BIT   = 3'd4,
        ST_ACK_STOP  = 3'd5
    } rx_state_e;

    typedef enum logic [1:0] {
        AK_IDLE  = 2'd0,
        AK_START = 2'd1,
        AK_BIT   = 2'd2,
        AK_STOP  = 2'd3
    } ack_phase_e;

endpackage

// File: rtl/otn_rx_deser_ack_ack_ser.sv
// ACK serializer: start bit 0, verdict bit, stop bit 0, each one baud long, line idles high.
module ack_ser
    import otn_rx_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_baud_en,
    input  logic i_start,
    input  logic i_good,
    output logic o_tx,
    output logic o_busy,
    output logic o_step
);

    ack_phase_e r_phase;
    logic [4:0] r_cnt;
    logic       r_good;
    logic       r_tx;
    logic       w_step;

    // Last enable of the current baud; the parent FSM advances on the same edge
    assign w_step = (r_phase != AK_IDLE) && i_baud_en && (r_cnt == 5'(BAUD_DIV - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_phase <= AK_IDLE;
            r_cnt   <= '0;
            r_good  <= 1'b0;
            r_tx    <= 1'b1;
        end else if (i_start) begin
            r_phase <= AK_START;
            r_cnt   <= '0;
            r_good  <= i_good;
            r_tx    <= 1'b0;
        end else if (r_phase != AK_IDLE && i_baud_en) begin
            if (w_step) begin
                r_cnt <= '0;
                case (r_phase)
                    AK_START: begin
                        r_phase <= AK_BIT;
                        r_tx    <= r_good;
                    end
                    AK_BIT: begin
                        r_phase <= AK_STOP;
                        r_tx    <= 1'b0;
                    end
                    default: begin
                        r_phase <= AK_IDLE;
                        r_tx    <= 1'b1;
                    end
                endcase
            end else begin
                r_cnt <= r_cnt + 5'd1;
            end
        end
    end

    assign o_tx   = r_tx;
    assign o_busy = (r_phase != AK_IDLE);
    assign o_step = w_step;

endmodule

// File: rtl/otn_rx_deser_ack.sv
// OTN receive side: oversample and align on FAS, deserialize LSB-first bytes to the demapper,
// then return the demapper's frame verdict to the sender as a serial ACK.
module otn_rx_deser_ack
    import otn_rx_pkg::*;
#(
    parameter int FRAME_BYTES = FRAME_BYTES_DEF,
    parameter int BAUD_DIV    = BAUD_DIV_DEF,
    parameter int SAMPLE_PT   = SAMPLE_PT_DEF,
    parameter int CHK_TIMEOUT = CHK_TIMEOUT_DEF
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_sclk_en_16_x_baud,
    input  logic       i_otn_rx_data,
    output logic [7:0] o_frame_data,
    output logic       o_frame_data_valid,
    output logic       o_frame_data_fas,
    output logic       o_frame_done,
    input  logic       i_chk_valid,
    input  logic       i_chk_good,
    output logic       o_otn_tx_ack,
    output logic [2:0] o_rx_state
);

    localparam int TO_W = $clog2(CHK_TIMEOUT + 1);

    rx_state_e       r_state;
    logic            r_sync1, r_sync2, r_prev;
    logic [4:0]      r_tick;
    logic [47:0]     r_hunt;
    logic [7:0]      r_byte;
    logic [2:0]      r_bit_cnt;
    logic [12:0]     r_byte_cnt;
    logic [TO_W-1:0] r_to;

    logic        w_edge, w_sample, w_timeout;
    logic        w_ack_start, w_ack_good, w_ack_busy, w_ack_step;
    logic [47:0] w_hunt_nxt;
    logic [7:0]  w_byte_nxt;
    logic [12:0] w_cnt_nxt;

    assign w_edge      = (r_sync2 != r_prev) && (r_state == ST_HUNT || r_state == ST_RECV);
    assign w_sample    = i_sclk_en_16_x_baud && (r_tick == 5'(SAMPLE_PT));
    assign w_hunt_nxt  = {r_sync2, r_hunt[47:1]};
    assign w_byte_nxt  = {r_sync2, r_byte[7:1]};
    assign w_cnt_nxt   = r_byte_cnt + 13'd1;
    assign w_timeout   = (r_to == TO_W'(CHK_TIMEOUT));
    // A verdict arriving on the timeout clock still wins
    assign w_ack_start = (r_state == ST_CHK_WAIT) && (i_chk_valid || w_timeout);
    assign w_ack_good  = i_chk_valid & i_chk_good;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_prev  <= 1'b1;
        end else begin
            r_sync1 <= i_otn_rx_data;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Edges re-centre the sample point; long runs free-run at one sample per baud
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_tick <= '0;
        else if (w_edge)
            r_tick <= '0;
        else if (i_sclk_en_16_x_baud)
            r_tick <= (r_tick == 5'(BAUD_DIV - 1)) ? 5'd0 : r_tick + 5'd1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state            <= ST_HUNT;
            r_hunt             <= '0;
            r_byte             <= '0;
            r_bit_cnt          <= '0;
            r_byte_cnt         <= '0;
            r_to               <= '0;
            o_frame_data       <= '0;
            o_frame_data_valid <= 1'b0;
            o_frame_data_fas   <= 1'b0;
            o_frame_done       <= 1'b0;
        end else begin
            o_frame_data_valid <= 1'b0;
            o_frame_data_fas   <= 1'b0;
            o_frame_done       <= 1'b0;
            case (r_state)
                ST_HUNT: begin
                    if (w_sample) begin
                        r_hunt <= w_hunt_nxt;
                        if (w_hunt_nxt == FAS) begin
                            o_frame_data_fas <= 1'b1;
                            r_byte_cnt       <= '0;
                            r_bit_cnt        <= '0;
                            r_state          <= ST_RECV;
                        end
                    end
                end
                ST_RECV: begin
                    if (w_sample) begin
                        r_byte    <= w_byte_nxt;
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            o_frame_data       <= w_byte_nxt;
                            o_frame_data_valid <= 1'b1;
                            r_byte_cnt         <= w_cnt_nxt;
                            if (w_cnt_nxt == 13'(FRAME_BYTES - 6)) begin
                                o_frame_done <= 1'b1;
                                r_to         <= '0;
                                r_state      <= ST_CHK_WAIT;
                            end
                        end
                    end
                end
                ST_CHK_WAIT: begin
                    if (w_ack_start)
                        r_state <= ST_ACK_START;
                    else
                        r_to <= r_to + 1'b1;
                end
                ST_ACK_START, ST_ACK_BIT, ST_ACK_STOP: begin
                    // Tracks the serializer; an idle serializer means the ACK is over
                    if (!w_ack_busy || (r_state == ST_ACK_STOP && w_ack_step)) begin
                        r_state <= ST_HUNT;
                        r_hunt  <= '0;
                    end else if (w_ack_step) begin
                        r_state <= (r_state == ST_ACK_START) ? ST_ACK_BIT : ST_ACK_STOP;
                    end
                end
                default: begin
                    r_state <= ST_HUNT;
                    r_hunt  <= '0;
                end
            endcase
        end
    end

    ack_ser #(
        .BAUD_DIV (BAUD_DIV)
    ) u_ack_ser (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_baud_en (i_sclk_en_16_x_baud),
        .i_start   (w_ack_start),
        .i_good    (w_ack_good),
        .o_tx      (o_otn_tx_ack),
        .o_busy    (w_ack_busy),
        .o_step    (w_ack_step)
    );

    assign o_rx_state = r_state;

endmodule
